// File: rtl/alu_result_checker_if.sv
// Snoop bus carrying ALU requests (operands/opcode) and ALU responses (result/flags).
interface alu_result_checker_if;
    logic       mon_valid_in;
    logic [3:0] mon_a;
    logic [3:0] mon_b;
    logic       mon_cin;
    logic [3:0] mon_ctl;
    logic       mon_valid_out;
    logic [3:0] mon_alu;
    logic       mon_carry;
    logic       mon_zero;

    modport master (
        output mon_valid_in, mon_a, mon_b, mon_cin, mon_ctl,
        output mon_valid_out, mon_alu, mon_carry, mon_zero
    );

    modport slave (
        input mon_valid_in, mon_a, mon_b, mon_cin, mon_ctl,
        input mon_valid_out, mon_alu, mon_carry, mon_zero
    );
endinterface

// File: rtl/alu_result_checker.sv
// In-order scoreboard for the 4-bit ALU: queues golden results and checks responses, 1-cycle min response latency.
// Passive snooper, no backpressure: pushes into a full queue are dropped and flagged, stale heads time out.
module alu_result_checker #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    alu_result_checker_if.slave         mon,
    output logic [CNT_W-1:0]            correct_count,
    output logic [CNT_W-1:0]            incorrect_count,
    output logic [$clog2(FIFO_DEPTH):0] outstanding,
    output logic                        busy,
    output logic                        mismatch,
    output logic [5:0]                  exp_result,
    output logic                        err_unexpected,
    output logic                        err_overflow,
    output logic                        err_timeout
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]      DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t           state, state_nxt;
    logic [4:0]       r;
    logic [5:0]       golden;
    logic [5:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, count, count_nxt;
    logic [AGE_W-1:0] age;
    logic [5:0]       head, resp;
    logic             empty, full, flush;
    logic             pop_cmp, pop_to, pop_any, push_ok;
    logic             overflow, unexpected, cmp_bad;

    // Golden model; for the shifts the shifted-out bit is placed in r[4] so carry is always r[4].
    always_comb begin
        r = 5'd0;
        case (mon.mon_ctl)
            4'h0:    r = {1'b0, mon.mon_a} + {1'b0, mon.mon_b} + {4'd0, mon.mon_cin};
            4'h1:    r = {1'b0, mon.mon_a} - {1'b0, mon.mon_b} - {4'd0, mon.mon_cin};
            4'h2:    r = {1'b0, mon.mon_a & mon.mon_b};
            4'h3:    r = {1'b0, mon.mon_a | mon.mon_b};
            4'h4:    r = {1'b0, mon.mon_a ^ mon.mon_b};
            4'h5:    r = {1'b0, ~mon.mon_a};
            4'h6:    r = {1'b0, mon.mon_a} + 5'd1;
            4'h7:    r = {1'b0, mon.mon_a} - 5'd1;
            4'h8:    r = {mon.mon_a[3], mon.mon_a[2:0], 1'b0};
            4'h9:    r = {mon.mon_a[0], 1'b0, mon.mon_a[3:1]};
            default: r = 5'd0;
        endcase
        golden = {r[3:0], r[4], (r[3:0] == 4'd0)};
    end

    assign flush      = reset || clear;
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_V);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign resp       = {mon.mon_alu, mon.mon_carry, mon.mon_zero};
    assign pop_cmp    = mon.mon_valid_out && !empty;
    // A response arriving on the timeout cycle is compared rather than discarded.
    assign pop_to     = !empty && !pop_cmp && (age == AGE_LAST);
    assign pop_any    = pop_cmp || pop_to;
    assign push_ok    = mon.mon_valid_in && (!full || pop_any);
    assign overflow   = mon.mon_valid_in && full && !pop_any;
    assign unexpected = mon.mon_valid_out && empty;
    assign cmp_bad    = pop_cmp && (head != resp);
    assign count_nxt  = count + (AW + 1)'(push_ok) - (AW + 1)'(pop_any);
    assign outstanding = count;
    assign busy       = (state == TRACK);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= golden;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push_ok) state_nxt = TRACK;
            TRACK:   if (count_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            age             <= '0;
            correct_count   <= '0;
            incorrect_count <= '0;
            mismatch        <= 1'b0;
            exp_result      <= '0;
            err_unexpected  <= 1'b0;
            err_overflow    <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop_any) rd_ptr <= rd_ptr + (AW + 1)'(1);

            if (pop_any || empty) begin
                age <= '0;
            end else begin
                age <= age + AGE_W'(1);
            end

            if (pop_cmp && !cmp_bad && (correct_count != '1)) begin
                correct_count <= correct_count + CNT_W'(1);
            end
            // Mismatch, unexpected response and timeout are mutually exclusive in a cycle.
            if ((cmp_bad || unexpected || pop_to) && (incorrect_count != '1)) begin
                incorrect_count <= incorrect_count + CNT_W'(1);
            end

            mismatch <= cmp_bad;
            if (cmp_bad)    exp_result     <= head;
            if (unexpected) err_unexpected <= 1'b1;
            if (overflow)   err_overflow   <= 1'b1;
            if (pop_to)     err_timeout    <= 1'b1;
        end
    end
endmodule
